// File: rtl/chia7bit_pkg.sv
// Shared definitions for the chia7bit restoring divider: FSM encoding and default widths.
package chia7bit_pkg;

  localparam int N_W_DEFAULT = 7;
  localparam int D_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/tru4bit.sv
// Ripple subtractor a - b built as a + ~b + 1; borrow is high when b > a.
module tru4bit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // A carry out of the top bit means no borrow was needed.
  assign borrow = ~carry[W];

endmodule

// File: rtl/chia7bit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, MSB first.
// Handshake: start is a one-cycle request taken only in IDLE; busy is high during CALC;
// done pulses for one cycle when Q/R/dz are valid; results then hold until the next DONE.
module chia7bit
  import chia7bit_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT,
  parameter int D_W = D_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] N,
  input  logic [D_W-1:0] D,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           busy,
  output logic           done,
  output logic           dz,
  output state_t         state_dbg
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  state_t         state;
  logic [N_W-1:0] n_reg;
  logic [D_W-1:0] d_reg;
  logic [D_W:0]   rem;
  logic [CNT_W-1:0] cnt;

  logic [D_W:0]   shifted;
  logic [D_W:0]   diff;
  logic           borrow;
  logic           keep;
  logic [D_W:0]   rem_next;

  // n_reg doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign shifted = {rem[D_W-1:0], n_reg[N_W-1]};

  tru4bit #(.W(D_W + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, d_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  // rem stays below D, so its top bit only acts as an overflow guard.
  assign keep     = ~borrow | rem[D_W];
  assign rem_next = keep ? diff : shifted;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n_reg <= '0;
      d_reg <= '0;
      rem   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_reg <= N;
            d_reg <= D;
            if (D == '0) begin
              Q     <= '1;
              R     <= '0;
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rem   <= '0;
              cnt   <= CNT_W'(N_W - 1);
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          n_reg <= {n_reg[N_W-2:0], keep};
          rem   <= rem_next;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            Q     <= {n_reg[N_W-2:0], keep};
            R     <= rem_next[D_W-1:0];
            dz    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
